// File: rtl/tlc_input_conditioner_if.sv
// Purpose : conditioner <-> environment/consumer signal bundle.
// Ports   : raw_in, ack (into conditioner); level_out, rise_pulse, fall_pulse,
//           req, miss_cnt (out of conditioner).
// Modports: master = conditioner side, slave = board/consumer side.
interface tlc_input_conditioner_if #(
  parameter int unsigned N_CH = 4
);
  localparam int unsigned MISS_W = 4 * N_CH;

  logic [N_CH-1:0]   raw_in;
  logic [N_CH-1:0]   level_out;
  logic [N_CH-1:0]   rise_pulse;
  logic [N_CH-1:0]   fall_pulse;
  logic [N_CH-1:0]   req;
  logic [N_CH-1:0]   ack;
  logic [MISS_W-1:0] miss_cnt;

  modport master (
    input  raw_in, ack,
    output level_out, rise_pulse, fall_pulse, req, miss_cnt
  );

  modport slave (
    output raw_in, ack,
    input  level_out, rise_pulse, fall_pulse, req, miss_cnt
  );
endinterface

// File: rtl/tlc_input_conditioner.sv
// Purpose : per-channel 2-FF synchroniser, counter debouncer, edge detector and
//           sticky request latch ahead of TLC_main.
// Ports   : clk   - system clock
//           reset - asynchronous active-low reset (0 = reset)
//           bus   - tlc_input_conditioner_if.master (raw_in, ack in;
//                   level_out, rise_pulse, fall_pulse, req, miss_cnt out)
// Config  : define TLC_INCOND_MISSCNT_EN to build the saturating 4-bit
//           per-channel missed-request counters; otherwise miss_cnt is 0.
module tlc_input_conditioner #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  tlc_input_conditioner_if.master  bus
);
  localparam int unsigned MISS_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [N_CH-1:0]  s1_q, s2_q;
  logic [N_CH-1:0]  level_q, level_d;
  logic [N_CH-1:0]  rise_q, rise_d;
  logic [N_CH-1:0]  fall_q, fall_d;
  logic [N_CH-1:0]  req_q, req_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  // Debounce, edge detection and request latch next-state
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    req_d   = req_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = s2_q[i];
        rise_d[i]  = s2_q[i];
        fall_d[i]  = ~s2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      // A new rising event takes priority over a coincident ack
      if (rise_q[i]) begin
        req_d[i] = 1'b1;
      end else if (bus.ack[i]) begin
        req_d[i] = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      req_q   <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q    <= bus.raw_in;
      s2_q    <= s1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      req_q   <= req_d;
      for (int i = 0; i < int'(N_CH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.level_out  = level_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.req        = req_q;

`ifdef TLC_INCOND_MISSCNT_EN
  logic [MISS_W-1:0] miss_q [N_CH];

  // Count rises that land on an already-pending request; saturate at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        miss_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        if (rise_q[i] && req_q[i] && (miss_q[i] != {MISS_W{1'b1}})) begin
          miss_q[i] <= miss_q[i] + MISS_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_miss
    assign bus.miss_cnt[MISS_W*g +: MISS_W] = miss_q[g];
  end
`else
  assign bus.miss_cnt = '0;
`endif

endmodule

// File: tb/tb_tlc_input_conditioner.sv
// Purpose : directed self-checking bench for tlc_input_conditioner with
//           DB_CYCLES=8, CNT_W=4 (level change on the 10th edge after a raw change).
module tb_tlc_input_conditioner;
  localparam int unsigned N_CH = 4;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  tlc_input_conditioner_if #(.N_CH(N_CH)) bus ();

  tlc_input_conditioner #(
    .N_CH      (N_CH),
    .DB_CYCLES (8),
    .CNT_W     (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; drive and sample 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    bus.raw_in = '0;
    bus.ack    = '0;
    reset      = 1'b0;
    ticks(2);
    reset      = 1'b1;
  endtask

  task automatic pulse_ch0();
    bus.raw_in[0] = 1'b1;
    ticks(12);
    bus.raw_in[0] = 1'b0;
    ticks(12);
  endtask

  logic [3:0] miss_exp_1;
  logic [3:0] miss_exp_15;

  initial begin
    n_vec = 0;
    n_err = 0;
`ifdef TLC_INCOND_MISSCNT_EN
    miss_exp_1  = 4'd1;
    miss_exp_15 = 4'd15;
`else
    miss_exp_1  = 4'd0;
    miss_exp_15 = 4'd0;
`endif
    reset      = 1'b1;
    bus.raw_in = 4'hF;
    bus.ack    = 4'h0;

    // 1: asynchronous reset, then all channels high after release
    #2 reset = 1'b0;
    #1;
    chk("rst_level", bus.level_out, 4'h0);
    chk("rst_rise",  bus.rise_pulse, 4'h0);
    chk("rst_fall",  bus.fall_pulse, 4'h0);
    chk("rst_req",   bus.req, 4'h0);
    chk("rst_miss",  bus.miss_cnt, 16'h0);
    ticks(2);
    reset = 1'b1;
    ticks(9);
    chk("t1_level_e9", bus.level_out, 4'h0);
    tick();
    chk("t1_level_e10", bus.level_out, 4'hF);
    chk("t1_rise_e10",  bus.rise_pulse, 4'hF);
    chk("t1_req_e10",   bus.req, 4'h0);
    tick();
    chk("t1_rise_e11", bus.rise_pulse, 4'h0);
    chk("t1_req_e11",  bus.req, 4'hF);
    chk("t1_fall_e11", bus.fall_pulse, 4'h0);

    // 2: 7-cycle glitch on ch2 is rejected
    do_reset();
    bus.raw_in[2] = 1'b1;
    ticks(7);
    bus.raw_in[2] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t2_ch2_quiet", {bus.level_out[2], bus.rise_pulse[2], bus.req[2]}, 3'b000);
    end

    // 3: ch3 debounced rise, request held until ack
    do_reset();
    bus.raw_in[3] = 1'b1;
    ticks(9);
    chk("t3_level_e9", bus.level_out[3], 1'b0);
    tick();
    chk("t3_level_e10", bus.level_out[3], 1'b1);
    chk("t3_rise_e10",  bus.rise_pulse[3], 1'b1);
    ticks(4);
    chk("t3_req_held", bus.req, 4'h8);
    bus.ack[3] = 1'b1;
    tick();
    chk("t3_req_acked", bus.req[3], 1'b0);
    bus.ack[3] = 1'b0;

    // 4: ack coinciding with rise loses to the set; held ack clears next edge
    do_reset();
    bus.raw_in[1] = 1'b1;
    ticks(10);
    chk("t4_rise", bus.rise_pulse[1], 1'b1);
    bus.ack[1] = 1'b1;
    tick();
    chk("t4_req_set_wins", bus.req[1], 1'b1);
    tick();
    chk("t4_req_cleared", bus.req[1], 1'b0);
    bus.ack[1] = 1'b0;

    // 5: missed-request counting on ch0 with no ack
    do_reset();
    pulse_ch0();
    pulse_ch0();
    chk("t5_miss_after2", bus.miss_cnt[3:0], miss_exp_1);
    for (int k = 0; k < 15; k++) pulse_ch0();
    chk("t5_miss_sat",  bus.miss_cnt[3:0], miss_exp_15);
    chk("t5_miss_other", bus.miss_cnt[15:4], 12'h0);
    chk("t5_req0",      bus.req[0], 1'b1);

    // 6: falling edge, then reset asserted mid-count
    do_reset();
    bus.raw_in[0] = 1'b1;
    ticks(11);
    chk("t6_req_up", bus.req[0], 1'b1);
    bus.raw_in[0] = 1'b0;
    ticks(9);
    chk("t6_level_e9", bus.level_out[0], 1'b1);
    tick();
    chk("t6_level_e10", bus.level_out[0], 1'b0);
    chk("t6_fall_e10",  bus.fall_pulse[0], 1'b1);
    chk("t6_rise_e10",  bus.rise_pulse[0], 1'b0);
    tick();
    chk("t6_fall_e11", bus.fall_pulse[0], 1'b0);
    chk("t6_req_kept", bus.req[0], 1'b1);
    bus.raw_in[0] = 1'b1;
    ticks(10);
    chk("t6_level_high", bus.level_out[0], 1'b1);
    bus.raw_in[0] = 1'b0;
    ticks(5);
    reset = 1'b0;
    #1;
    chk("t6_rst_level", bus.level_out, 4'h0);
    chk("t6_rst_req",   bus.req, 4'h0);
    #2 reset = 1'b1;
    bus.raw_in[0] = 1'b1;
    ticks(9);
    chk("t6_recount_e9", bus.level_out[0], 1'b0);
    tick();
    chk("t6_recount_e10", bus.level_out[0], 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
